// File: rtl/avg_pkg.sv
// Shared definitions for the sample feeder and the averager it drives.
// Sample width, default frame length and phase counter width live here.
package avg_pkg;

    localparam int SAMPLE_W      = 8;
    localparam int FRAME_LEN_DEF = 8;
    localparam int PHASE_W       = 3;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [PHASE_W-1:0]  phase_t;

    function automatic phase_t phase_next(input phase_t p, input int len);
        if (p == phase_t'(len - 1))
            return '0;
        return p + phase_t'(1);
    endfunction

    function automatic logic is_last(input phase_t p, input int len);
        return p == phase_t'(len - 1);
    endfunction

endpackage

// File: rtl/avg_feed_if.sv
// Producer-side and averager-side signals of avg_feed.
// master drives writes and observes; slave is the feeder itself.
interface avg_feed_if #(
    parameter int DEPTH = 8
);
    import avg_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic          wr_en;
    sample_t       wr_data;
    logic          full;
    logic [CW-1:0] count;
    sample_t       out_num;
    logic          frame_strobe;
    phase_t        phase;
    logic          underflow;
    logic          overflow;

    modport master (
        output wr_en,
        output wr_data,
        input  full,
        input  count,
        input  out_num,
        input  frame_strobe,
        input  phase,
        input  underflow,
        input  overflow
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output full,
        output count,
        output out_num,
        output frame_strobe,
        output phase,
        output underflow,
        output overflow
    );

endinterface

// File: rtl/avg_fifo.sv
// Circular sample buffer with occupancy count; head is read combinationally.
// Callers must not push when full nor pop when empty.
module avg_fifo
    import avg_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rs,
    input  logic          push,
    input  logic          pop,
    input  sample_t       wdata,
    output sample_t       data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    sample_t         mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rs) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign data  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/avg_feed.sv
// Frame-paced sample feeder for the averager: buffers producer samples and
// emits one per FRAME_LEN cycles. Optional macro: AVG_FEED_ZERO_FILL_EN.
module avg_feed
    import avg_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic clk,
    input  logic rs,
    avg_feed_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    phase_t        phase;
    sample_t       out_num;
    logic          frame_strobe;
    logic          underflow;
    logic          overflow;

    sample_t       head;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop_evt;
    logic          push;
    logic          pop;

    // A write seen while full is dropped even if this cycle also pops.
    assign pop_evt = !rs && is_last(phase, FRAME_LEN);
    assign push    = !rs && bus.wr_en && !full;
    assign pop     = pop_evt && !empty;

    avg_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rs    (rs),
        .push  (push),
        .pop   (pop),
        .wdata (bus.wr_data),
        .data  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rs) begin
            phase        <= '0;
            out_num      <= '0;
            frame_strobe <= 1'b0;
            underflow    <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            phase        <= phase_next(phase, FRAME_LEN);
            frame_strobe <= pop_evt;
            if (pop_evt) begin
                if (!empty) begin
                    out_num <= head;
                end else begin
                    underflow <= 1'b1;
`ifdef AVG_FEED_ZERO_FILL_EN
                    out_num   <= '0;
`endif
                end
            end
            if (bus.wr_en && full)
                overflow <= 1'b1;
        end
    end

    assign bus.phase        = phase;
    assign bus.out_num      = out_num;
    assign bus.frame_strobe = frame_strobe;
    assign bus.underflow    = underflow;
    assign bus.overflow     = overflow;
    assign bus.count        = count;
    assign bus.full         = full;

endmodule

// File: tb/tb_avg_feed.sv
// Directed scenarios plus randomized traffic for avg_feed, checked against
// a queue-based frame model.
module tb_avg_feed;

    localparam int DEPTH = 8;
    localparam int FL    = 8;

    logic clk = 1'b0;
    logic rs  = 1'b1;

    avg_feed_if #(.DEPTH(DEPTH)) bus ();

    avg_feed #(
        .DEPTH     (DEPTH),
        .FRAME_LEN (FL)
    ) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int mq[$];
    int mphase, mout, mstrobe, muf, mof;
    int seen[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Frame model: one sample leaves per frame, in arrival order.
    task automatic model(input logic r, input logic we, input int d);
        bit was_full;
        bit pop_now;
        if (r) begin
            mq.delete();
            mphase = 0; mout = 0; mstrobe = 0; muf = 0; mof = 0;
        end else begin
            was_full = (mq.size() == DEPTH);
            pop_now  = (mphase == FL - 1);
            mstrobe  = pop_now ? 1 : 0;
            if (pop_now) begin
                if (mq.size() > 0) begin
                    mout = mq.pop_front();
                end else begin
                    muf = 1;
`ifdef AVG_FEED_ZERO_FILL_EN
                    mout = 0;
`endif
                end
            end
            if (we) begin
                if (was_full) mof = 1;
                else mq.push_back(d);
            end
            mphase = pop_now ? 0 : mphase + 1;
        end
    endtask

    task automatic check_all();
        chk("phase",     32'(bus.phase),        mphase);
        chk("count",     32'(bus.count),        mq.size());
        chk("full",      32'(bus.full),         (mq.size() == DEPTH) ? 1 : 0);
        chk("out_num",   32'(bus.out_num),      mout);
        chk("strobe",    32'(bus.frame_strobe), mstrobe);
        chk("underflow", 32'(bus.underflow),    muf);
        chk("overflow",  32'(bus.overflow),     mof);
    endtask

    task automatic step(input logic r, input logic we, input int d);
        rs          = r;
        bus.wr_en   = we;
        bus.wr_data = d[7:0];
        @(posedge clk);
        model(r, we, d & 255);
        #1;
        check_all();
        if (bus.frame_strobe === 1'b1)
            seen.push_back(int'(bus.out_num));
    endtask

    initial begin
        int n;
        int pct;
        int exp55;
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;

        // Reset then idle: strobes every frame, underflow after the first.
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        chk("r029_uf", 32'(bus.underflow), 1);
        chk("r029_out", 32'(bus.out_num), 0);

        // Three consecutive writes emerge on three consecutive strobes.
        step(1, 0, 0);
        seen.delete();
        step(0, 1, 10);
        step(0, 1, 20);
        step(0, 1, 30);
        chk("r030_cnt3", 32'(bus.count), 3);
        for (int i = 0; i < 30; i++) step(0, 0, 0);
        chk("r030_s0", seen.size() > 0 ? seen[0] : -1, 10);
        chk("r030_s1", seen.size() > 1 ? seen[1] : -1, 20);
        chk("r030_s2", seen.size() > 2 ? seen[2] : -1, 30);

        // Continuous writes fill the buffer and overflow.
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 100 + i);
        chk("r031_ovf", 32'(bus.overflow), 1);
        chk("r031_full", 32'(bus.full), 1);
        n = 0;
        while (mphase != FL - 1 && n < FL) begin
            step(0, 1, $urandom_range(0, 255));
            n++;
        end
        chk("r032_full", 32'(bus.full), 1);
        step(0, 1, 99);
        chk("r032_cnt", 32'(bus.count), 7);
        chk("r032_ovf", 32'(bus.overflow), 1);
        for (int i = 0; i < 80; i++) step(0, 0, 0);

        // Mid-frame reset with data buffered.
        step(1, 0, 0);
        seen.delete();
        for (int i = 0; i < 4; i++) step(0, 1, 40 + i);
        n = 0;
        while (seen.size() < 2 && n < 40) begin step(0, 0, 0); n++; end
        n = 0;
        while (mphase != 3 && n < FL) begin step(0, 0, 0); n++; end
        chk("r033_pre", 32'(bus.count), 2);
        step(1, 1, 77);
        chk("r033_cnt", 32'(bus.count), 0);
        chk("r033_ph", 32'(bus.phase), 0);
        chk("r033_out", 32'(bus.out_num), 0);
        chk("r033_ovf", 32'(bus.overflow), 0);
        chk("r033_uf", 32'(bus.underflow), 0);
        n = 0;
        while (n < 20) begin
            step(0, 0, 0);
            n++;
            if (bus.frame_strobe === 1'b1) break;
        end
        chk("r033_lat", n, 8);

        // Empty pop after 55 was emitted.
        step(1, 0, 0);
        seen.delete();
        step(0, 1, 55);
        n = 0;
        while (seen.size() < 2 && n < 30) begin step(0, 0, 0); n++; end
`ifdef AVG_FEED_ZERO_FILL_EN
        exp55 = 0;
`else
        exp55 = 55;
`endif
        chk("r034_s0", seen.size() > 0 ? seen[0] : -1, 55);
        chk("r034_s1", seen.size() > 1 ? seen[1] : -1, exp55);
        chk("r034_uf", 32'(bus.underflow), 1);

        // Randomized traffic at several write rates with rare resets.
        for (int blk = 0; blk < 8; blk++) begin
            pct = (blk % 4 == 0) ? 5 : (blk % 4 == 1) ? 12 :
                  (blk % 4 == 2) ? 25 : 60;
            for (int i = 0; i < 100; i++)
                step(($urandom_range(0, 149) == 0),
                     ($urandom_range(0, 99) < pct),
                     $urandom_range(0, 255));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
